// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between the decode stage, register file,
// forwarding network and the ALU for the alu_issue block.
interface alu_issue_if;
    logic               in_valid;
    logic               in_ready;
    logic        [31:0] instr;
    logic        [4:0]  rs1_addr;
    logic        [4:0]  rs2_addr;
    logic        [31:0] rs1_data;
    logic        [31:0] rs2_data;
    logic               fwd_valid;
    logic        [4:0]  fwd_rd;
    logic        [31:0] fwd_data;
    logic               out_valid;
    logic               out_ready;
    logic        [4:0]  alu_op;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic        [4:0]  rd;
    logic               illegal;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data,
        input  fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, rs1_addr, rs2_addr,
        output out_valid, alu_op, op_a, op_b, rd, illegal
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data,
        output fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr,
        input  out_valid, alu_op, op_a, op_b, rd, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32 OP/OP-IMM decode and one-deep issue register feeding the ALU.
// Define ALU_ISSUE_FWD_EN to bypass in-flight results instead of stalling on hazards.
module alu_issue (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [4:0] ALU_ADD     = 5'd0;
    localparam logic [4:0] ALU_SUB     = 5'd1;
    localparam logic [4:0] ALU_AND     = 5'd2;
    localparam logic [4:0] ALU_OR      = 5'd3;
    localparam logic [4:0] ALU_XOR     = 5'd4;
    localparam logic [4:0] ALU_LSHIFT  = 5'd5;
    localparam logic [4:0] ALU_LRSHIFT = 5'd6;
    localparam logic [4:0] ALU_ARSHIFT = 5'd7;
    localparam logic [4:0] ALU_MUL     = 5'd8;
    localparam logic [4:0] ALU_DIV     = 5'd9;
    localparam logic [4:0] ALU_DIVU    = 5'd10;
    localparam logic [4:0] ALU_REM     = 5'd11;
    localparam logic [4:0] ALU_REMU    = 5'd12;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign funct7       = bus.instr[31:25];
    assign bus.rs1_addr = bus.instr[19:15];
    assign bus.rs2_addr = bus.instr[24:20];

    logic               dec_legal;
    logic               dec_use_rs2;
    logic               dec_imm_sel;
    logic        [4:0]  dec_op;
    logic signed [31:0] dec_imm;

    always_comb begin
        dec_legal   = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_imm_sel = 1'b0;
        dec_op      = ALU_ADD;
        dec_imm     = '0;
        if (opcode == OPC_OP) begin
            dec_legal   = 1'b1;
            dec_use_rs2 = 1'b1;
            case ({funct7, funct3})
                {7'h00, 3'd0}: dec_op = ALU_ADD;
                {7'h00, 3'd1}: dec_op = ALU_LSHIFT;
                {7'h00, 3'd4}: dec_op = ALU_XOR;
                {7'h00, 3'd5}: dec_op = ALU_LRSHIFT;
                {7'h00, 3'd6}: dec_op = ALU_OR;
                {7'h00, 3'd7}: dec_op = ALU_AND;
                {7'h20, 3'd0}: dec_op = ALU_SUB;
                {7'h20, 3'd5}: dec_op = ALU_ARSHIFT;
                {7'h01, 3'd0}: dec_op = ALU_MUL;
                {7'h01, 3'd4}: dec_op = ALU_DIV;
                {7'h01, 3'd5}: dec_op = ALU_DIVU;
                {7'h01, 3'd6}: dec_op = ALU_REM;
                {7'h01, 3'd7}: dec_op = ALU_REMU;
                default:       dec_legal = 1'b0;
            endcase
        end else if (opcode == OPC_OPIMM) begin
            dec_legal   = 1'b1;
            dec_imm_sel = 1'b1;
            dec_imm     = {{20{bus.instr[31]}}, bus.instr[31:20]};
            case (funct3)
                3'd0: dec_op = ALU_ADD;
                3'd4: dec_op = ALU_XOR;
                3'd6: dec_op = ALU_OR;
                3'd7: dec_op = ALU_AND;
                3'd1: begin
                    dec_op    = ALU_LSHIFT;
                    dec_imm   = {27'd0, bus.instr[24:20]};
                    dec_legal = (funct7 == 7'h00);
                end
                3'd5: begin
                    dec_imm = {27'd0, bus.instr[24:20]};
                    if (funct7 == 7'h00)      dec_op = ALU_LRSHIFT;
                    else if (funct7 == 7'h20) dec_op = ALU_ARSHIFT;
                    else                      dec_legal = 1'b0;
                end
                default: dec_legal = 1'b0;
            endcase
        end
        if (!dec_legal) dec_use_rs2 = 1'b0;
    end

    // A source only matters when the decoded instruction actually reads it.
    logic haz_rs1;
    logic haz_rs2;
    logic stall;

    assign haz_rs1 = dec_legal & bus.fwd_valid & (bus.fwd_rd != 5'd0) & (bus.fwd_rd == bus.rs1_addr);
    assign haz_rs2 = dec_use_rs2 & bus.fwd_valid & (bus.fwd_rd != 5'd0) & (bus.fwd_rd == bus.rs2_addr);

    logic signed [31:0] src1;
    logic signed [31:0] src2;

    always_comb begin
        src1 = (bus.rs1_addr == 5'd0) ? '0 : bus.rs1_data;
        src2 = (bus.rs2_addr == 5'd0) ? '0 : bus.rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        if (haz_rs1) src1 = bus.fwd_data;
        if (haz_rs2) src2 = bus.fwd_data;
`endif
    end

`ifdef ALU_ISSUE_FWD_EN
    assign stall = 1'b0;
`else
    logic unused_fwd;
    assign unused_fwd = ^bus.fwd_data;
    assign stall      = bus.in_valid & (haz_rs1 | haz_rs2);
`endif

    logic               out_valid_q, out_valid_d;
    logic               illegal_q, illegal_d;
    logic        [4:0]  alu_op_q, alu_op_d;
    logic signed [31:0] op_a_q, op_a_d;
    logic signed [31:0] op_b_q, op_b_d;
    logic        [4:0]  rd_q, rd_d;
    logic               accept;

    assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~stall;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        alu_op_d    = alu_op_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        if (accept) begin
            out_valid_d = 1'b1;
            illegal_d   = ~dec_legal;
            if (dec_legal) begin
                alu_op_d = dec_op;
                op_a_d   = src1;
                op_b_d   = dec_imm_sel ? dec_imm : src2;
                rd_d     = bus.instr[11:7];
            end else begin
                alu_op_d = ALU_ADD;
                op_a_d   = '0;
                op_b_d   = '0;
                rd_d     = '0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_op_q    <= ALU_ADD;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            alu_op_q    <= alu_op_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.rd        = rd_q;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed scenarios plus random traffic
// checked against a table-driven reference of the issue rules.
module tb_alu_issue;
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_AND = 5'd2, A_OR = 5'd3, A_XOR = 5'd4;
    localparam logic [4:0] A_LSH = 5'd5, A_LRSH = 5'd6, A_ARSH = 5'd7, A_MUL = 5'd8;
    localparam logic [4:0] A_DIV = 5'd9, A_DIVU = 5'd10, A_REM = 5'd11, A_REMU = 5'd12;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Legal register-register encodings as {funct7, funct3} -> alu_op rows.
    localparam logic [6:0] OP_F7  [13] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20,
                                           7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [2:0] OP_F3  [13] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd5,
                                           3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [4:0] OP_ALU [13] = '{A_ADD, A_LSH, A_XOR, A_LRSH, A_OR, A_AND, A_SUB, A_ARSH,
                                           A_MUL, A_DIV, A_DIVU, A_REM, A_REMU};

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t pend;
    bit   acc_pending = 1'b0;
    bit   model_full  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ref_decode(input logic [31:0] ins, output logic [4:0] alu,
                                      output bit imm_form, output bit uses_rs2,
                                      output logic [31:0] immv);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        alu = A_ADD; imm_form = 1'b0; uses_rs2 = 1'b0; immv = '0;
        if (opc == 7'h33) begin
            for (int i = 0; i < 13; i++)
                if (OP_F7[i] == f7 && OP_F3[i] == f3) begin
                    alu = OP_ALU[i];
                    uses_rs2 = 1'b1;
                    return 1'b1;
                end
            return 1'b0;
        end
        if (opc == 7'h13) begin
            imm_form = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                immv = {27'd0, ins[24:20]};
                if (f3 == 3'd1 && f7 == 7'h00) begin alu = A_LSH;  return 1'b1; end
                if (f3 == 3'd5 && f7 == 7'h00) begin alu = A_LRSH; return 1'b1; end
                if (f3 == 3'd5 && f7 == 7'h20) begin alu = A_ARSH; return 1'b1; end
                return 1'b0;
            end
            imm = int'(ins[31:20]);
            if (imm >= 2048) imm = imm - 4096;
            immv = imm;
            if (f3 == 3'd0) begin alu = A_ADD; return 1'b1; end
            if (f3 == 3'd4) begin alu = A_XOR; return 1'b1; end
            if (f3 == 3'd6) begin alu = A_OR;  return 1'b1; end
            if (f3 == 3'd7) begin alu = A_AND; return 1'b1; end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] data,
                                            input bit fv, input logic [4:0] frd, input logic [31:0] fd);
        if (addr == 5'd0) return 32'd0;
        if (FWD_EN && fv && frd == addr) return fd;
        return data;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins, input bit fv, input logic [4:0] frd);
        logic [4:0]  alu;
        bit          immf, u2, legal;
        logic [31:0] immv;
        legal = ref_decode(ins, alu, immf, u2, immv);
        return legal && fv && frd != 5'd0 && (frd == ins[19:15] || (u2 && frd == ins[24:20]));
    endfunction

    function automatic exp_t ref_issue(input logic [31:0] ins, input logic [31:0] r1d, input logic [31:0] r2d,
                                       input bit fv, input logic [4:0] frd, input logic [31:0] fd);
        exp_t        e;
        logic [4:0]  alu;
        bit          immf, u2, legal;
        logic [31:0] immv;
        legal = ref_decode(ins, alu, immf, u2, immv);
        if (!legal) begin
            e.op = A_ADD; e.a = '0; e.b = '0; e.rd = '0; e.ill = 1'b1;
        end else begin
            e.op  = alu;
            e.a   = ref_src(ins[19:15], r1d, fv, frd, fd);
            e.b   = immf ? immv : ref_src(ins[24:20], r2d, fv, frd, fd);
            e.rd  = ins[11:7];
            e.ill = 1'b0;
        end
        return e;
    endfunction

    // One clock of stimulus; in_ready is judged against the slot/hazard model.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] r1d, input logic [31:0] r2d,
                         input bit fv, input logic [4:0] frd, input logic [31:0] fd, input bit ordy);
        bit stall, exp_ready;
        @(posedge clk);
        #1;
        if (acc_pending) sb_q.push_back(pend);
        bus.in_valid = iv; bus.instr = ins; bus.rs1_data = r1d; bus.rs2_data = r2d;
        bus.fwd_valid = fv; bus.fwd_rd = frd; bus.fwd_data = fd; bus.out_ready = ordy;
        @(negedge clk);
        stall     = !FWD_EN && iv && ref_hazard(ins, fv, frd);
        exp_ready = (!model_full || ordy) && !stall;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        acc_pending = iv && exp_ready;
        if (acc_pending) pend = ref_issue(ins, r1d, r2d, fv, frd, fd);
        model_full = acc_pending || (model_full && !ordy);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
                if (bus.out_valid && sb_q.size() != 0) begin
                    e = sb_q[0];
                    chk("alu_op", 32'(bus.alu_op), 32'(e.op));
                    chk("op_a", bus.op_a, e.a);
                    chk("op_b", bus.op_b, e.b);
                    chk("rd", 32'(bus.rd), 32'(e.rd));
                    chk("illegal", 32'(bus.illegal), 32'(e.ill));
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7, opc;
        logic [2:0] f3;
        logic [4:0] r1, r2, rdv;
        int         k;
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rdv = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        k   = $urandom_range(0, 9);
        if (k >= 8) return $urandom;
        opc = (k < 4) ? 7'h33 : 7'h13;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'h01;
        endcase
        if (opc == 7'h13 && f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
        return {f7, r2, r1, f3, rdv, opc};
    endfunction

    localparam logic [31:0] I_ADDI  = 32'hFFF00293;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_ADD5  = 32'h002082B3;
    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_SLT   = 32'h0020A1B3;
    localparam logic [31:0] I_ADDX0 = 32'h00200233;

    initial begin
        bus.in_valid = 1'b0; bus.instr = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.fwd_valid = 1'b0; bus.fwd_rd = '0; bus.fwd_data = '0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_op_a", bus.op_a, 32'd0);
        chk("reset_alu_op", 32'(bus.alu_op), 32'(A_ADD));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fork monitor_loop(); join_none

        // ADDI x5,x0,-1
        cycle(1'b1, I_ADDI, 32'h1234, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("addi_op_b", bus.op_b, 32'hFFFFFFFF);
        chk("addi_op_a", bus.op_a, 32'd0);
        chk("addi_rd", 32'(bus.rd), 32'd5);

        // SRAI x1,x2,3
        cycle(1'b1, I_SRAI, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("srai_alu_op", 32'(bus.alu_op), 32'(A_ARSH));
        chk("srai_op_a", bus.op_a, 32'h80000000);
        chk("srai_op_b", bus.op_b, 32'd3);

        // SUB held for three stalled cycles, next op accepted as out_ready rises
        cycle(1'b1, I_SUB, 32'd100, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, I_ADD5, 32'd9, 32'd11, 1'b0, 5'd0, 32'd0, 1'b0);
            chk("stall_alu_op", 32'(bus.alu_op), 32'(A_SUB));
            chk("stall_op_a", bus.op_a, 32'd100);
        end
        cycle(1'b1, I_ADD5, 32'd9, 32'd11, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("post_stall_rd", 32'(bus.rd), 32'd5);

        // ADD x3,x1,x2 against an in-flight write of x1
        cycle(1'b1, I_ADD3, 32'h55, 32'h66, 1'b1, 5'd1, 32'h10, 1'b1);
        chk("fwd_in_ready", 32'(bus.in_ready), 32'(FWD_EN));
        cycle(1'b1, I_ADD3, 32'h55, 32'h66, 1'b1, 5'd1, 32'h10, 1'b1);
        cycle(1'b1, I_ADD3, 32'h55, 32'h66, 1'b0, 5'd1, 32'h10, 1'b1);
        idle(1'b1);
        chk("fwd_released_op_a", bus.op_a, 32'h55);

        // SLT is illegal; x0 source ignores a forward to x0
        cycle(1'b1, I_SLT, 32'h77, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("slt_illegal", 32'(bus.illegal), 32'd1);
        chk("slt_op_b", bus.op_b, 32'd0);
        cycle(1'b1, I_ADDX0, 32'h77, 32'h88, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        idle(1'b1);
        chk("x0_op_a", bus.op_a, 32'd0);

        // Asynchronous reset while stalled
        cycle(1'b1, I_ADDI, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_op_b", bus.op_b, 32'd0);
        chk("async_rst_rd", 32'(bus.rd), 32'd0);
        sb_q.delete();
        acc_pending = 1'b0;
        model_full  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, I_ADDI, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) < 7);

        repeat (4) idle(1'b1);
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
